c7bexu_lsu: RTL and testbench

Load/store unit for the c7bexu execute pipeline and the producer side of the LSU-to-ECL status interface. It accepts one memory operation from E, checks alignment in LS1, runs a single request/response transaction on the data bus, and reports exactly one terminating event to the ECL: misaligned-address exception in LS1, or load-data-valid, store-finished, bus-error or ECC-error in LS3. One operation is in flight at a time. The ECL holds the pipeline stalled until that terminating event.

---
 rtl/c7bexu_lsu.sv | 152 +++++++++++++++
 tb/tb_c7bexu_lsu.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/c7bexu_lsu.sv
// c7bexu_lsu: load/store unit for the c7bexu execute pipeline.
// Accepts one memory operation from E, checks alignment in LS1, runs one
// request/response transaction on the data bus and reports exactly one
// terminating event to the ECL (ALE in LS1; buserr/ecc/data_valid/wr_fin in LS3).
// Ports:
//   clk, resetn                  clock, synchronous active-low reset
//   lsu_*_e                      operation issued from E (sampled when idle)
//   lsu_busy                     operation in flight
//   lsu_except_*, lsu_ecl_*      one-cycle status pulses and payload to the ECL
//   lsu_bus_*                    data bus request side
//   bus_lsu_*                    data bus ack/response side
// Every output is decoded from registered state only.
module c7bexu_lsu (
  input  logic        clk,
  input  logic        resetn,
  input  logic        lsu_vld_e,
  input  logic        lsu_wr_e,
  input  logic [1:0]  lsu_size_e,
  input  logic        lsu_sign_e,
  input  logic [31:0] lsu_addr_e,
  input  logic [31:0] lsu_wdata_e,
  input  logic [4:0]  lsu_rd_e,
  output logic        lsu_busy,
  output logic        lsu_except_ale_ls1,
  output logic        lsu_except_buserr_ls3,
  output logic        lsu_except_ecc_ls3,
  output logic        lsu_ecl_data_valid_ls3,
  output logic        lsu_ecl_wr_fin_ls3,
  output logic [31:0] lsu_ecl_rdata_ls3,
  output logic [4:0]  lsu_ecl_rd_ls3,
  output logic [31:0] lsu_ecl_badaddr,
  output logic        lsu_bus_req,
  output logic        lsu_bus_wr,
  output logic [31:0] lsu_bus_addr,
  output logic [31:0] lsu_bus_wdata,
  output logic [3:0]  lsu_bus_be,
  input  logic        bus_lsu_ack,
  input  logic        bus_lsu_rvld,
  input  logic [31:0] bus_lsu_rdata,
  input  logic        bus_lsu_err,
  input  logic        bus_lsu_ecc
);

  typedef enum logic [2:0] {StIdle, StLs1, StReq, StWait, StLs3} state_e;

  state_e      state_q, state_d;
  logic        wr_q, sign_q, err_q, ecc_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [4:0]  rd_q;

  logic        misaligned;
  logic [3:0]  be;
  logic [31:0] wdata_rep;
  logic [31:0] rdata_shift;
  logic [31:0] rdata_ext;

  always_comb begin
    unique case (size_q)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = addr_q[0];
      2'd2:    misaligned = |addr_q[1:0];
      default: misaligned = 1'b1;
    endcase
  end

  // Byte enables, lane-replicated write data and load extraction, all from
  // the captured operation.
  always_comb begin
    be          = 4'b1111;
    wdata_rep   = wdata_q;
    rdata_shift = rdata_q >> {addr_q[1:0], 3'b000};
    rdata_ext   = rdata_q;
    unique case (size_q)
      2'd0: begin
        be          = 4'b0001 << addr_q[1:0];
        wdata_rep   = {4{wdata_q[7:0]}};
        rdata_shift = rdata_q >> {addr_q[1:0], 3'b000};
        rdata_ext   = {{24{sign_q & rdata_shift[7]}}, rdata_shift[7:0]};
      end
      2'd1: begin
        be          = 4'b0011 << {addr_q[1], 1'b0};
        wdata_rep   = {2{wdata_q[15:0]}};
        rdata_shift = rdata_q >> {addr_q[1], 4'b0000};
        rdata_ext   = {{16{sign_q & rdata_shift[15]}}, rdata_shift[15:0]};
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (lsu_vld_e) state_d = StLs1;
      StLs1:  state_d = misaligned ? StIdle : StReq;
      StReq:  if (bus_lsu_ack) state_d = StWait;
      StWait: if (bus_lsu_rvld) state_d = StLs3;
      StLs3:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= StIdle;
      wr_q    <= 1'b0;
      size_q  <= 2'd0;
      sign_q  <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rd_q    <= 5'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
      ecc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && lsu_vld_e) begin
        wr_q    <= lsu_wr_e;
        size_q  <= lsu_size_e;
        sign_q  <= lsu_sign_e;
        addr_q  <= lsu_addr_e;
        wdata_q <= lsu_wdata_e;
        rd_q    <= lsu_rd_e;
      end
      if (state_q == StWait && bus_lsu_rvld) begin
        rdata_q <= bus_lsu_rdata;
        err_q   <= bus_lsu_err;
        ecc_q   <= bus_lsu_ecc;
      end
    end
  end

  always_comb begin
    lsu_busy               = (state_q != StIdle);
    lsu_except_ale_ls1     = (state_q == StLs1) && misaligned;
    lsu_except_buserr_ls3  = (state_q == StLs3) && err_q;
    // ECC is only meaningful for loads; a store with ECC still finishes.
    lsu_except_ecc_ls3     = (state_q == StLs3) && !err_q && !wr_q && ecc_q;
    lsu_ecl_data_valid_ls3 = (state_q == StLs3) && !err_q && !wr_q && !ecc_q;
    lsu_ecl_wr_fin_ls3     = (state_q == StLs3) && !err_q && wr_q;
    lsu_ecl_rdata_ls3      = lsu_ecl_data_valid_ls3 ? rdata_ext : 32'd0;
    lsu_ecl_rd_ls3         = lsu_ecl_data_valid_ls3 ? rd_q : 5'd0;
    lsu_ecl_badaddr        = (lsu_except_ale_ls1 || lsu_except_buserr_ls3 ||
                              lsu_except_ecc_ls3) ? addr_q : 32'd0;
    lsu_bus_req            = (state_q == StReq);
    lsu_bus_wr             = lsu_bus_req && wr_q;
    lsu_bus_addr           = lsu_bus_req ? {addr_q[31:2], 2'b00} : 32'd0;
    lsu_bus_wdata          = lsu_bus_req ? wdata_rep : 32'd0;
    lsu_bus_be             = lsu_bus_req ? be : 4'd0;
  end

endmodule

// File: tb/tb_c7bexu_lsu.sv
// Scoreboard bench for c7bexu_lsu: stimulus pushes expected ECL events and
// bus requests into queues; a negedge monitor pops and compares them.
module tb_c7bexu_lsu;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        lsu_vld_e = 1'b0, lsu_wr_e = 1'b0, lsu_sign_e = 1'b0;
  logic [1:0]  lsu_size_e = 2'd0;
  logic [31:0] lsu_addr_e = 32'd0, lsu_wdata_e = 32'd0;
  logic [4:0]  lsu_rd_e = 5'd0;
  logic        lsu_busy, lsu_except_ale_ls1, lsu_except_buserr_ls3, lsu_except_ecc_ls3;
  logic        lsu_ecl_data_valid_ls3, lsu_ecl_wr_fin_ls3;
  logic [31:0] lsu_ecl_rdata_ls3, lsu_ecl_badaddr;
  logic [4:0]  lsu_ecl_rd_ls3;
  logic        lsu_bus_req, lsu_bus_wr;
  logic [31:0] lsu_bus_addr, lsu_bus_wdata;
  logic [3:0]  lsu_bus_be;
  logic        bus_lsu_ack = 1'b0, bus_lsu_rvld = 1'b0, bus_lsu_err = 1'b0, bus_lsu_ecc = 1'b0;
  logic [31:0] bus_lsu_rdata = 32'd0;

  c7bexu_lsu dut (
    .clk(clk), .resetn(resetn),
    .lsu_vld_e(lsu_vld_e), .lsu_wr_e(lsu_wr_e), .lsu_size_e(lsu_size_e),
    .lsu_sign_e(lsu_sign_e), .lsu_addr_e(lsu_addr_e), .lsu_wdata_e(lsu_wdata_e),
    .lsu_rd_e(lsu_rd_e), .lsu_busy(lsu_busy),
    .lsu_except_ale_ls1(lsu_except_ale_ls1), .lsu_except_buserr_ls3(lsu_except_buserr_ls3),
    .lsu_except_ecc_ls3(lsu_except_ecc_ls3), .lsu_ecl_data_valid_ls3(lsu_ecl_data_valid_ls3),
    .lsu_ecl_wr_fin_ls3(lsu_ecl_wr_fin_ls3), .lsu_ecl_rdata_ls3(lsu_ecl_rdata_ls3),
    .lsu_ecl_rd_ls3(lsu_ecl_rd_ls3), .lsu_ecl_badaddr(lsu_ecl_badaddr),
    .lsu_bus_req(lsu_bus_req), .lsu_bus_wr(lsu_bus_wr), .lsu_bus_addr(lsu_bus_addr),
    .lsu_bus_wdata(lsu_bus_wdata), .lsu_bus_be(lsu_bus_be),
    .bus_lsu_ack(bus_lsu_ack), .bus_lsu_rvld(bus_lsu_rvld), .bus_lsu_rdata(bus_lsu_rdata),
    .bus_lsu_err(bus_lsu_err), .bus_lsu_ecc(bus_lsu_ecc)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  localparam logic [4:0] KAle = 5'b10000, KBus = 5'b01000, KEcc = 5'b00100;
  localparam logic [4:0] KDv = 5'b00010, KFin = 5'b00001;

  typedef struct {
    logic [4:0]  kind;
    int          at;
    logic [31:0] rdata;
    logic [4:0]  rd;
    logic [31:0] badaddr;
  } exp_t;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } bus_t;

  exp_t exp_q[$];
  bus_t bus_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got 0x%08h want 0x%08h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Monitor: ECL pulses against exp_q, bus requests against bus_q.
  always @(negedge clk) begin
    logic [4:0] pulses;
    exp_t e;
    bus_t b;
    pulses = {lsu_except_ale_ls1, lsu_except_buserr_ls3, lsu_except_ecc_ls3,
              lsu_ecl_data_valid_ls3, lsu_ecl_wr_fin_ls3};
    if (pulses != 5'd0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {27'd0, pulses}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("pulse_kind", {27'd0, pulses}, {27'd0, e.kind});
        check("pulse_cycle", cyc, e.at);
        if (e.kind == KDv) begin
          check("rdata_ls3", lsu_ecl_rdata_ls3, e.rdata);
          check("rd_ls3", {27'd0, lsu_ecl_rd_ls3}, {27'd0, e.rd});
        end
        if (e.kind == KAle || e.kind == KBus || e.kind == KEcc)
          check("badaddr", lsu_ecl_badaddr, e.badaddr);
      end
    end
    if (lsu_bus_req) begin
      if (bus_q.size() == 0) begin
        check("unexpected_bus_req", {31'd0, lsu_bus_req}, 32'd0);
      end else begin
        b = bus_q[0];
        check("bus_wr", {31'd0, lsu_bus_wr}, {31'd0, b.wr});
        check("bus_addr", lsu_bus_addr, b.addr);
        check("bus_wdata", lsu_bus_wdata, b.wdata);
        check("bus_be", {28'd0, lsu_bus_be}, {28'd0, b.be});
        if (bus_lsu_ack) void'(bus_q.pop_front());
      end
    end
  end

  task automatic check_all_zero(input string name);
    logic [31:0] v;
    v = {26'd0, lsu_busy, lsu_except_ale_ls1, lsu_except_buserr_ls3, lsu_except_ecc_ls3,
         lsu_ecl_data_valid_ls3, lsu_ecl_wr_fin_ls3};
    check({name, "_status"}, v, 32'd0);
    check({name, "_payload"}, lsu_ecl_rdata_ls3 | lsu_ecl_badaddr | {27'd0, lsu_ecl_rd_ls3}, 32'd0);
    check({name, "_bus"}, lsu_bus_addr | lsu_bus_wdata |
          {26'd0, lsu_bus_req, lsu_bus_wr, lsu_bus_be}, 32'd0);
  endtask

  // One operation; ack arrives ack_wait cycles after req first rises, rvld the cycle after ack.
  task automatic run_op(input logic wr, input logic [1:0] size, input logic sign,
                        input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd,
                        input bit ale, input int ack_wait, input logic [31:0] rsp,
                        input logic err, input logic ecc, input logic [4:0] kind,
                        input logic [31:0] exp_rdata, input logic [3:0] exp_be,
                        input logic [31:0] exp_wdata);
    int n;
    int r;
    exp_t e;
    bus_t b;
    @(posedge clk); #1;
    lsu_vld_e = 1'b1; lsu_wr_e = wr; lsu_size_e = size; lsu_sign_e = sign;
    lsu_addr_e = addr; lsu_wdata_e = wdata; lsu_rd_e = rd;
    n = cyc;
    if (ale) begin
      e.kind = KAle; e.at = n + 1; e.rdata = 32'd0; e.rd = 5'd0; e.badaddr = addr;
      exp_q.push_back(e);
    end else begin
      b.wr = wr; b.addr = {addr[31:2], 2'b00}; b.wdata = exp_wdata; b.be = exp_be;
      bus_q.push_back(b);
    end
    @(posedge clk); #1;
    lsu_vld_e = 1'b0;
    check("busy_ls1", {31'd0, lsu_busy}, 32'd1);
    if (ale) begin
      @(posedge clk); #1;
      check("busy_after_ale", {31'd0, lsu_busy}, 32'd0);
      check("no_req_after_ale", {31'd0, lsu_bus_req}, 32'd0);
    end else begin
      for (int i = 0; i <= ack_wait; i++) begin
        @(posedge clk); #1;
        bus_lsu_ack = (i == ack_wait);
        if (i == 0) check("req_at_n2", {31'd0, lsu_bus_req}, 32'd1);
      end
      @(posedge clk); #1;
      bus_lsu_ack = 1'b0;
      bus_lsu_rvld = 1'b1; bus_lsu_rdata = rsp; bus_lsu_err = err; bus_lsu_ecc = ecc;
      r = cyc;
      e.kind = kind; e.at = r + 1; e.rdata = exp_rdata; e.rd = rd; e.badaddr = addr;
      exp_q.push_back(e);
      @(posedge clk); #1;
      bus_lsu_rvld = 1'b0; bus_lsu_rdata = 32'd0; bus_lsu_err = 1'b0; bus_lsu_ecc = 1'b0;
      @(posedge clk); #1;
      check("busy_after_ls3", {31'd0, lsu_busy}, 32'd0);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    resetn = 1'b1;

    // Aligned word load: pulse at N+4, idle at N+5.
    run_op(1'b0, 2'd2, 1'b0, 32'h100, 32'd0, 5'd5, 1'b0, 0, 32'hDEADBEEF, 1'b0, 1'b0,
           KDv, 32'hDEADBEEF, 4'b1111, 32'd0);
    // Byte loads at 0x103, signed then unsigned.
    run_op(1'b0, 2'd0, 1'b1, 32'h103, 32'd0, 5'd7, 1'b0, 0, 32'h80FF_0000, 1'b0, 1'b0,
           KDv, 32'hFFFF_FF80, 4'b1000, 32'd0);
    run_op(1'b0, 2'd0, 1'b0, 32'h103, 32'd0, 5'd8, 1'b0, 1, 32'h80FF_0000, 1'b0, 1'b0,
           KDv, 32'h0000_0080, 4'b1000, 32'd0);
    // Half store, req held three cycles until ack.
    run_op(1'b1, 2'd1, 1'b0, 32'h102, 32'h0000_1234, 5'd0, 1'b0, 2, 32'd0, 1'b0, 1'b0,
           KFin, 32'd0, 4'b1100, 32'h1234_1234);
    // Misaligned word, reserved size, misaligned half.
    run_op(1'b0, 2'd2, 1'b0, 32'h101, 32'd0, 5'd1, 1'b1, 0, 32'd0, 1'b0, 1'b0,
           KAle, 32'd0, 4'd0, 32'd0);
    run_op(1'b1, 2'd3, 1'b0, 32'h0, 32'd0, 5'd1, 1'b1, 0, 32'd0, 1'b0, 1'b0,
           KAle, 32'd0, 4'd0, 32'd0);
    run_op(1'b0, 2'd1, 1'b0, 32'h301, 32'd0, 5'd1, 1'b1, 0, 32'd0, 1'b0, 1'b0,
           KAle, 32'd0, 4'd0, 32'd0);
    // Error responses.
    run_op(1'b0, 2'd2, 1'b0, 32'h200, 32'd0, 5'd3, 1'b0, 0, 32'h5555_AAAA, 1'b1, 1'b1,
           KBus, 32'd0, 4'b1111, 32'd0);
    run_op(1'b0, 2'd2, 1'b0, 32'h204, 32'd0, 5'd3, 1'b0, 0, 32'h5555_AAAA, 1'b0, 1'b1,
           KEcc, 32'd0, 4'b1111, 32'd0);
    run_op(1'b1, 2'd0, 1'b0, 32'h205, 32'h0000_00AB, 5'd0, 1'b0, 0, 32'd0, 1'b0, 1'b1,
           KFin, 32'd0, 4'b0010, 32'hABAB_ABAB);
    // Signed half load from the upper lane.
    run_op(1'b0, 2'd1, 1'b1, 32'h206, 32'd0, 5'd31, 1'b0, 1, 32'h8001_1234, 1'b0, 1'b0,
           KDv, 32'hFFFF_8001, 4'b1100, 32'd0);

    // Reset while waiting for the response, then a late rvld.
    begin
      bus_t b;
      @(posedge clk); #1;
      lsu_vld_e = 1'b1; lsu_wr_e = 1'b0; lsu_size_e = 2'd2; lsu_sign_e = 1'b0;
      lsu_addr_e = 32'h80; lsu_wdata_e = 32'd0; lsu_rd_e = 5'd9;
      b.wr = 1'b0; b.addr = 32'h80; b.wdata = 32'd0; b.be = 4'b1111;
      bus_q.push_back(b);
      @(posedge clk); #1;
      lsu_vld_e = 1'b0;
      @(posedge clk); #1;
      bus_lsu_ack = 1'b1;
      @(posedge clk); #1;
      bus_lsu_ack = 1'b0;
      resetn = 1'b0;
      @(posedge clk); #1;
      check_all_zero("reset_in_wait");
      resetn = 1'b1;
      @(posedge clk); #1;
      bus_lsu_rvld = 1'b1; bus_lsu_rdata = 32'h1234_5678;
      @(posedge clk); #1;
      bus_lsu_rvld = 1'b0; bus_lsu_rdata = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("after_late_rvld");
    end

    // Next load completes normally.
    run_op(1'b0, 2'd2, 1'b0, 32'h40, 32'd0, 5'd12, 1'b0, 0, 32'h0BAD_F00D, 1'b0, 1'b0,
           KDv, 32'h0BAD_F00D, 4'b1111, 32'd0);

    repeat (3) @(posedge clk);
    #1;
    check("pending_events", exp_q.size(), 32'd0);
    check("pending_bus", bus_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
